sram_pipe: RTL

SRAM_PIPE -- requirements
Module: sram_pipe

---
 rtl/sram_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sram_pipe.sv
// sram_pipe: single-clock word-addressed SRAM with one write port (lane
// masked) and one fully pipelined read port. It has a configurable read latency,
// optional same-cycle write-to-read forwarding, address range checking and
// a saturating counter of same-word read/write collisions.
`timescale 1ns/1ps
module sram_pipe #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1,
    parameter int FORWARD_EN   = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] write_mask,
    input  logic                             read_enable,
    input  logic [ADDR_WIDTH-1:0]            read_address,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             read_valid,
    output logic                             addr_error,
    output logic [15:0]                      conflict_count
);

    localparam int LANES      = DATA_WIDTH / LANE_WIDTH;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    // Expand the per-lane write mask into a per-bit mask.
    function automatic logic [DATA_WIDTH-1:0] lane_expand(input logic [LANES-1:0] mask);
        logic [DATA_WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < LANES; i++) begin
            bits[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{mask[i]}};
        end
        return bits;
    endfunction

    // Storage is deliberately not reset so contents survive a reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read pipeline: stage 0 is loaded at the sampling edge, the last stage
    // drives the outputs.
    logic                  r_vld [READ_LATENCY];
    logic                  r_err [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [READ_LATENCY];
    logic                  w_in_vld [READ_LATENCY];
    logic                  w_in_err [READ_LATENCY];
    logic [DATA_WIDTH-1:0] w_in_dat [READ_LATENCY];

    logic                  r_wr_err;
    logic [15:0]           r_conflict_count;

    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_wr_oob;
    logic                  w_rd_oob;
    logic                  w_wr_fire;
    logic                  w_wr_err;
    logic                  w_rd_fire;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_bits;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Address decode, range check and request qualification (requests are
    // ignored while reset is asserted).
    always_comb begin
        w_wr_idx  = write_address >> BYTE_SHIFT;
        w_rd_idx  = read_address >> BYTE_SHIFT;
        w_wr_oob  = $isunknown(write_address) || ((w_wr_idx >> DEPTH_LOG2) != '0);
        w_rd_oob  = $isunknown(read_address) || ((w_rd_idx >> DEPTH_LOG2) != '0);
        w_wr_fire = write_enable & ~reset & ~w_wr_oob;
        w_wr_err  = write_enable & ~reset & w_wr_oob;
        w_rd_fire = read_enable & ~reset;
        w_collide = w_wr_fire & w_rd_fire & ~w_rd_oob & (w_wr_idx == w_rd_idx);
        w_bits    = lane_expand(write_mask);
    end

    // Word captured by a read at its sampling edge: zero when out of range,
    // the merged word on a forwarded collision, otherwise the old contents.
    always_comb begin
        w_rd_old = r_mem[w_rd_idx[DEPTH_LOG2-1:0]];
        if (w_rd_oob) begin
            w_rd_word = '0;
        end else if ((FORWARD_EN != 0) && w_collide) begin
            w_rd_word = (write_data & w_bits) | (w_rd_old & ~w_bits);
        end else begin
            w_rd_word = w_rd_old;
        end
    end

    // Lane-masked write into the array.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            r_mem[w_wr_idx[DEPTH_LOG2-1:0]] <=
                (r_mem[w_wr_idx[DEPTH_LOG2-1:0]] & ~w_bits) | (write_data & w_bits);
        end
    end

    // Inputs of each pipeline stage: stage 0 from the sampled read, others
    // from the previous stage.
    always_comb begin
        w_in_vld[0] = w_rd_fire;
        w_in_err[0] = w_rd_fire & w_rd_oob;
        w_in_dat[0] = w_rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_in_vld[i] = r_vld[i-1];
            w_in_err[i] = r_err[i-1];
            w_in_dat[i] = r_dat[i-1];
        end
    end

    // Read pipeline registers; data only moves with a valid so the last
    // stage holds its value between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_err[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i] <= w_in_vld[i];
                r_err[i] <= w_in_err[i];
                if (w_in_vld[i]) begin
                    r_dat[i] <= w_in_dat[i];
                end
            end
        end
    end

    // One-cycle flag for a rejected out-of-range write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_err;
        end
    end

    // Saturating collision counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict_count <= 16'h0000;
        end else if (w_collide && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'h0001;
        end
    end

    assign read_data      = r_dat[READ_LATENCY-1];
    assign read_valid     = r_vld[READ_LATENCY-1];
    assign addr_error     = r_err[READ_LATENCY-1] | r_wr_err;
    assign conflict_count = r_conflict_count;

endmodule
